// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Store buffer between memory-stage issue logic and dmem. Stores queue in a
//   DEPTH-entry FIFO and drain into dmem one per cycle whenever no load holds
//   the shared port. Loads are checked against every pending store: a load
//   fully covered by the youngest overlapping store is forwarded, a partial
//   overlap stalls the load. A flush handshake empties the buffer.
//
//   Build option: define SB_FORWARD_EN to enable store-to-load forwarding.
//   Without it ld_hit/ld_fwd_data are tied low and any overlap stalls.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   st_valid/st_ready              store handshake
//   st_addr/st_data/st_sel         store address, low-aligned data, size select
//   ld_valid/ld_addr/ld_sel        load occupying the dmem port this cycle
//   ld_func3                       load extension type
//   ld_hit/ld_fwd_data/ld_stall    load check results
//   we_dmem/r_dmem_addr/
//   w_dmem_data/dmem_word_sel      drain write port to dmem
//   mem_exc_en/mem_exc_code        dmem fault for the drained store
//   drain_exc/drain_exc_code/
//   drain_exc_val                  drain fault pulse and latched code/address
//   flush_req/flush_done           flush level request and completion pulse
//
// Flush FSM
//   state   | meaning
//   S_IDLE  | normal operation, stores accepted
//   S_FLUSH | stores refused, draining until empty
//   S_DONE  | flush_done high for one cycle

module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_data,
    input  logic [7:0]  st_sel,
    input  logic        ld_valid,
    input  logic [63:0] ld_addr,
    input  logic [7:0]  ld_sel,
    input  logic [2:0]  ld_func3,
    output logic        ld_hit,
    output logic [63:0] ld_fwd_data,
    output logic        ld_stall,
    output logic        we_dmem,
    output logic [63:0] r_dmem_addr,
    output logic [63:0] w_dmem_data,
    output logic [7:0]  dmem_word_sel,
    input  logic        mem_exc_en,
    input  logic [3:0]  mem_exc_code,
    output logic        drain_exc,
    output logic [3:0]  drain_exc_code,
    output logic [63:0] drain_exc_val,
    input  logic        flush_req,
    output logic        flush_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic [63:0]        ent_addr [DEPTH];
    logic [63:0]        ent_data [DEPTH];
    logic [7:0]         ent_sel  [DEPTH];
    logic [7:0]         ent_mask [DEPTH];

    logic               push;
    logic               pop;
    logic [7:0]         st_mask;
    logic [7:0]         ld_mask;
    logic [PTR_W-1:0]   idx;
    logic               found;

    assign st_mask = st_sel << st_addr[2:0];
    assign ld_mask = ld_sel << ld_addr[2:0];

    assign st_ready = (count < CNT_W'(DEPTH)) && (state != S_FLUSH);
    assign push     = st_valid && st_ready;

    // The load owns the dmem port; reset cycle must not write dmem either.
    assign we_dmem       = (count != '0) && !ld_valid && !rst;
    assign pop           = we_dmem;
    assign r_dmem_addr   = ent_addr[head];
    assign w_dmem_data   = ent_data[head];
    assign dmem_word_sel = ent_sel[head];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

`ifdef SB_FORWARD_EN
    logic        cover;
    logic [63:0] fwd_raw;
    logic [63:0] fwd_ext;

    // Oldest to youngest; a later match overrides, so the youngest decides.
    always_comb begin
        found   = 1'b0;
        cover   = 1'b0;
        fwd_raw = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                (ent_addr[idx][63:3] == ld_addr[63:3]) &&
                ((ent_mask[idx] & ld_mask) != 8'h00)) begin
                found   = 1'b1;
                // sel encodings are ordered by size, so a numeric compare works
                cover   = (ent_addr[idx] == ld_addr) && (ent_sel[idx] >= ld_sel);
                fwd_raw = ent_data[idx];
            end
        end
    end

    always_comb begin
        case (ld_func3)
            3'b000:  fwd_ext = {{56{fwd_raw[7]}},  fwd_raw[7:0]};
            3'b001:  fwd_ext = {{48{fwd_raw[15]}}, fwd_raw[15:0]};
            3'b010:  fwd_ext = {{32{fwd_raw[31]}}, fwd_raw[31:0]};
            3'b100:  fwd_ext = {56'h0, fwd_raw[7:0]};
            3'b101:  fwd_ext = {48'h0, fwd_raw[15:0]};
            3'b110:  fwd_ext = {32'h0, fwd_raw[31:0]};
            default: fwd_ext = fwd_raw;
        endcase
    end

    assign ld_hit      = ld_valid && found && cover;
    assign ld_stall    = ld_valid && found && !cover;
    assign ld_fwd_data = ld_hit ? fwd_ext : 64'h0;
`else
    logic unused_func3;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                (ent_addr[idx][63:3] == ld_addr[63:3]) &&
                ((ent_mask[idx] & ld_mask) != 8'h00))
                found = 1'b1;
        end
    end

    assign unused_func3 = ^ld_func3;
    assign ld_hit       = 1'b0;
    assign ld_fwd_data  = 64'h0;
    assign ld_stall     = ld_valid && found;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            drain_exc      <= 1'b0;
            drain_exc_code <= 4'h0;
            drain_exc_val  <= 64'h0;
            flush_done     <= 1'b0;
        end else begin
            if (push) begin
                ent_addr[tail] <= st_addr;
                ent_data[tail] <= st_data;
                ent_sel[tail]  <= st_sel;
                ent_mask[tail] <= st_mask;
                tail           <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count_next;

            // A faulting drain still pops; the fault is reported afterwards.
            drain_exc <= pop && mem_exc_en;
            if (pop && mem_exc_en) begin
                drain_exc_code <= mem_exc_code;
                drain_exc_val  <= ent_addr[head];
            end

            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_req)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (count_next == '0) begin
                        state      <= S_DONE;
                        flush_done <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [7:0]  st_sel;
    logic        ld_valid;
    logic [63:0] ld_addr;
    logic [7:0]  ld_sel;
    logic [2:0]  ld_func3;
    logic        ld_hit;
    logic [63:0] ld_fwd_data;
    logic        ld_stall;
    logic        we_dmem;
    logic [63:0] r_dmem_addr;
    logic [63:0] w_dmem_data;
    logic [7:0]  dmem_word_sel;
    logic        mem_exc_en;
    logic [3:0]  mem_exc_code;
    logic        drain_exc;
    logic [3:0]  drain_exc_code;
    logic [63:0] drain_exc_val;
    logic        flush_req;
    logic        flush_done;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] FAR = 64'h0000_0000_9000_0000;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_sel(st_sel),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sel(ld_sel),
        .ld_func3(ld_func3), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
        .ld_stall(ld_stall),
        .we_dmem(we_dmem), .r_dmem_addr(r_dmem_addr), .w_dmem_data(w_dmem_data),
        .dmem_word_sel(dmem_word_sel),
        .mem_exc_en(mem_exc_en), .mem_exc_code(mem_exc_code),
        .drain_exc(drain_exc), .drain_exc_code(drain_exc_code),
        .drain_exc_val(drain_exc_val),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    // Waits for the falling edge and applies one cycle of stimulus.
    task automatic cyc(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                       input logic [7:0] ss, input logic lv, input logic [63:0] la,
                       input logic [7:0] ls, input logic [2:0] lf);
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd; st_sel = ss;
        ld_valid = lv; ld_addr = la; ld_sel = ls; ld_func3 = lf;
    endtask

    task automatic idle_cycle();
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 8'h00, 3'b000);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_exc_en = 1'b0; mem_exc_code = 4'h0; flush_req = 1'b0;
        idle_cycle();
        idle_cycle();
        rst = 1'b0;
        #1;
        tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
        tests++; if (we_dmem !== 1'b0) begin fails++; $display("FAIL reset_we_dmem got %b exp 0", we_dmem); end
        tests++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0) begin fails++; $display("FAIL reset_ld got hit=%b stall=%b exp 0/0", ld_hit, ld_stall); end
        tests++; if (drain_exc !== 1'b0 || drain_exc_code !== 4'h0 || drain_exc_val !== 64'h0) begin
            fails++; $display("FAIL reset_exc got %b %h %h exp 0 0 0", drain_exc, drain_exc_code, drain_exc_val); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
    endtask

    // Four SDs held back by a non-overlapping load, then drained in order.
    task automatic test_fill_drain();
        logic [63:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 64'h8000_2000 + 64'(8 * i);
            cyc(1'b1, a, 64'h100 + 64'(i), 8'hFF, 1'b1, FAR, 8'hFF, 3'b011);
            #1;
            tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d] got %b exp 1", i, st_ready); end
            tests++; if (we_dmem !== 1'b0 || ld_stall !== 1'b0) begin fails++; $display("FAIL fill_we[%0d] got we=%b stall=%b exp 0/0", i, we_dmem, ld_stall); end
        end
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, FAR, 8'hFF, 3'b011);
        #1;
        tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b exp 0", st_ready); end
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            #1;
            a = 64'h8000_2000 + 64'(8 * i);
            tests++; if (we_dmem !== 1'b1 || r_dmem_addr !== a || w_dmem_data !== 64'h100 + 64'(i) || dmem_word_sel !== 8'hFF) begin
                fails++; $display("FAIL drain[%0d] got we=%b a=%h d=%h s=%h exp 1 %h %h ff", i, we_dmem, r_dmem_addr, w_dmem_data, dmem_word_sel, a, 64'h100 + 64'(i)); end
        end
        idle_cycle();
        #1;
        tests++; if (we_dmem !== 1'b0 || st_ready !== 1'b1) begin fails++; $display("FAIL drain_empty got we=%b rdy=%b exp 0/1", we_dmem, st_ready); end
    endtask

    task automatic test_forward_word();
        cyc(1'b1, 64'h8000_0100, 64'h8000_00FF, 8'h0F, 1'b0, 64'h0, 8'h00, 3'b000);
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h8000_0100, 8'h0F, 3'b010);
        #1;
`ifdef SB_FORWARD_EN
        tests++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0) begin fails++; $display("FAIL fwd_lw_flags got hit=%b stall=%b exp 1/0", ld_hit, ld_stall); end
        tests++; if (ld_fwd_data !== 64'hFFFF_FFFF_8000_00FF) begin fails++; $display("FAIL fwd_lw_data got %h exp ffffffff800000ff", ld_fwd_data); end
`else
        tests++; if (ld_hit !== 1'b0 || ld_stall !== 1'b1) begin fails++; $display("FAIL fwd_lw_flags got hit=%b stall=%b exp 0/1", ld_hit, ld_stall); end
        tests++; if (ld_fwd_data !== 64'h0) begin fails++; $display("FAIL fwd_lw_data got %h exp 0", ld_fwd_data); end
`endif
        tests++; if (we_dmem !== 1'b0) begin fails++; $display("FAIL fwd_lw_port got we=%b exp 0", we_dmem); end
        idle_cycle();
        #1;
        tests++; if (we_dmem !== 1'b1 || w_dmem_data !== 64'h8000_00FF || dmem_word_sel !== 8'h0F) begin
            fails++; $display("FAIL fwd_lw_drain got we=%b d=%h s=%h exp 1 800000ff 0f", we_dmem, w_dmem_data, dmem_word_sel); end
    endtask

    task automatic test_partial_overlap();
        cyc(1'b1, 64'h8000_0103, 64'hAB, 8'h01, 1'b0, 64'h0, 8'h00, 3'b000);
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h8000_0100, 8'h0F, 3'b010);
        #1;
        tests++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin fails++; $display("FAIL partial_stall got stall=%b hit=%b exp 1/0", ld_stall, ld_hit); end
        idle_cycle();
        #1;
        tests++; if (we_dmem !== 1'b1 || r_dmem_addr !== 64'h8000_0103 || dmem_word_sel !== 8'h01) begin
            fails++; $display("FAIL partial_drain got we=%b a=%h s=%h exp 1 80000103 01", we_dmem, r_dmem_addr, dmem_word_sel); end
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h8000_0100, 8'h0F, 3'b010);
        #1;
        tests++; if (ld_stall !== 1'b0 || ld_hit !== 1'b0) begin fails++; $display("FAIL partial_retry got stall=%b hit=%b exp 0/0", ld_stall, ld_hit); end
    endtask

    task automatic test_youngest_wins();
        cyc(1'b1, 64'h8000_0200, 64'h11, 8'hFF, 1'b0, 64'h0, 8'h00, 3'b000);
        cyc(1'b1, 64'h8000_0200, 64'h22, 8'hFF, 1'b1, FAR, 8'hFF, 3'b011);
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h8000_0200, 8'hFF, 3'b011);
        #1;
`ifdef SB_FORWARD_EN
        tests++; if (ld_hit !== 1'b1 || ld_fwd_data !== 64'h22) begin fails++; $display("FAIL youngest got hit=%b d=%h exp 1 22", ld_hit, ld_fwd_data); end
`else
        tests++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin fails++; $display("FAIL youngest got stall=%b hit=%b exp 1/0", ld_stall, ld_hit); end
`endif
        idle_cycle();
        #1;
        tests++; if (we_dmem !== 1'b1 || w_dmem_data !== 64'h11) begin fails++; $display("FAIL youngest_drain0 got we=%b d=%h exp 1 11", we_dmem, w_dmem_data); end
        idle_cycle();
        #1;
        tests++; if (we_dmem !== 1'b1 || w_dmem_data !== 64'h22) begin fails++; $display("FAIL youngest_drain1 got we=%b d=%h exp 1 22", we_dmem, w_dmem_data); end
    endtask

    task automatic test_drain_exc();
        cyc(1'b1, 64'h8000_0201, 64'h5A, 8'h01, 1'b0, 64'h0, 8'h00, 3'b000);
        idle_cycle();
        mem_exc_en = 1'b1; mem_exc_code = 4'd6;
        #1;
        tests++; if (we_dmem !== 1'b1 || drain_exc !== 1'b0) begin fails++; $display("FAIL exc_drain got we=%b exc=%b exp 1/0", we_dmem, drain_exc); end
        idle_cycle();
        mem_exc_en = 1'b0; mem_exc_code = 4'd0;
        #1;
        tests++; if (drain_exc !== 1'b1 || drain_exc_code !== 4'd6 || drain_exc_val !== 64'h8000_0201) begin
            fails++; $display("FAIL exc_pulse got %b code=%0d val=%h exp 1 6 80000201", drain_exc, drain_exc_code, drain_exc_val); end
        tests++; if (we_dmem !== 1'b0) begin fails++; $display("FAIL exc_popped got we=%b exp 0", we_dmem); end
        idle_cycle();
        #1;
        tests++; if (drain_exc !== 1'b0 || drain_exc_code !== 4'd6 || drain_exc_val !== 64'h8000_0201) begin
            fails++; $display("FAIL exc_hold got %b code=%0d val=%h exp 0 6 80000201", drain_exc, drain_exc_code, drain_exc_val); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 64'h8000_0300 + 64'(8 * i), 64'(i), 8'hFF, 1'b1, FAR, 8'hFF, 3'b011);
        idle_cycle();
        flush_req = 1'b1;
        #1;
        tests++; if (we_dmem !== 1'b1 || flush_done !== 1'b0) begin fails++; $display("FAIL flush_f0 got we=%b done=%b exp 1/0", we_dmem, flush_done); end
        for (int i = 1; i < 3; i++) begin
            idle_cycle();
            #1;
            tests++; if (st_ready !== 1'b0 || flush_done !== 1'b0 || we_dmem !== 1'b1) begin
                fails++; $display("FAIL flush_f%0d got rdy=%b done=%b we=%b exp 0/0/1", i, st_ready, flush_done, we_dmem); end
        end
        idle_cycle();
        flush_req = 1'b0;
        #1;
        tests++; if (flush_done !== 1'b1 || we_dmem !== 1'b0) begin fails++; $display("FAIL flush_done got %b we=%b exp 1/0", flush_done, we_dmem); end
        idle_cycle();
        #1;
        tests++; if (flush_done !== 1'b0 || st_ready !== 1'b1) begin fails++; $display("FAIL flush_after got done=%b rdy=%b exp 0/1", flush_done, st_ready); end
    endtask

    task automatic test_reset_mid_flush();
        cyc(1'b1, 64'h8000_0400, 64'h1, 8'hFF, 1'b1, FAR, 8'hFF, 3'b011);
        cyc(1'b1, 64'h8000_0408, 64'h2, 8'hFF, 1'b1, FAR, 8'hFF, 3'b011);
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, FAR, 8'hFF, 3'b011);
        flush_req = 1'b1;
        cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, FAR, 8'hFF, 3'b011);
        #1;
        tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL midflush_ready got %b exp 0", st_ready); end
        idle_cycle();
        rst = 1'b1;
        #1;
        tests++; if (we_dmem !== 1'b0) begin fails++; $display("FAIL rst_no_drain got we=%b exp 0", we_dmem); end
        idle_cycle();
        rst = 1'b0; flush_req = 1'b0;
        #1;
        tests++; if (st_ready !== 1'b1 || we_dmem !== 1'b0 || flush_done !== 1'b0) begin
            fails++; $display("FAIL rst_mid_flush got rdy=%b we=%b done=%b exp 1/0/0", st_ready, we_dmem, flush_done); end
    endtask

    initial begin
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_sel = '0; ld_func3 = '0;
        rst = 1'b1; mem_exc_en = 1'b0; mem_exc_code = '0; flush_req = 1'b0;
        test_reset();
        test_fill_drain();
        test_forward_word();
        test_partial_overlap();
        test_youngest_wins();
        test_drain_exc();
        test_flush();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
